rf_alu_pipe: RTL and testbench

- Parametrised successor to the multicycle RISC register-file-plus-ALU datapath.
- Contains:
  - NUM_REGS x DATA_W register file.
  - Operand select (register or immediate).
  - Registered ID/EXE operand buffer.
  - Load-immediate builder (high/low half).
  - ALU with registered result and PSW flags (C, Z, N, V).
  - Iterative multi-cycle shifter with a Busy/Done handshake.
- Sits between the instruction decoder/controller and the memory/write-back mux of the multicycle core.

---
 rtl/rf_alu_pipe_if.sv | 46 ++++
 rtl/rf_alu_pipe.sv | 179 +++++++++++++++++
 tb/tb_rf_alu_pipe.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_alu_pipe_if.sv
// rf_alu_pipe_if: controller-side bundle for the register file / ALU datapath.
// The master drives decode controls; the slave returns operands, results and status.
interface rf_alu_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 5
);
    logic [ADDR_W-1:0]   WAddr;
    logic [ADDR_W-1:0]   RmAddr;
    logic [ADDR_W-1:0]   RnAddr;
    logic [ADDR_W-1:0]   RdAddr;
    logic [IMM_W-1:0]    Imm;
    logic [DATA_W/2-1:0] ImmL;
    logic [DATA_W-1:0]   WBData;
    logic                WBRF;
    logic [1:0]          WBresource;
    logic                RBresource;
    logic                OprandB;
    logic                LI;
    logic                Buff_IDEXE;
    logic                Exec;
    logic [2:0]          ALUop;
    logic                ShRight;
    logic                Flag;
    logic [DATA_W-1:0]   RmData;
    logic [DATA_W-1:0]   RdData;
    logic [DATA_W-1:0]   ResultR;
    logic [DATA_W-1:0]   LI_q;
    logic [3:0]          PSW;
    logic                Busy;
    logic                Done;

    modport master (
        output WAddr, RmAddr, RnAddr, RdAddr, Imm, ImmL, WBData, WBRF,
        output WBresource, RBresource, OprandB, LI, Buff_IDEXE, Exec,
        output ALUop, ShRight, Flag,
        input  RmData, RdData, ResultR, LI_q, PSW, Busy, Done
    );

    modport slave (
        input  WAddr, RmAddr, RnAddr, RdAddr, Imm, ImmL, WBData, WBRF,
        input  WBresource, RBresource, OprandB, LI, Buff_IDEXE, Exec,
        input  ALUop, ShRight, Flag,
        output RmData, RdData, ResultR, LI_q, PSW, Busy, Done
    );
endinterface

// File: rtl/rf_alu_pipe.sv
// rf_alu_pipe: register file, ID/EXE buffer, load-immediate builder, ALU and shifter.
// Define RF_BYPASS_EN for a write-first register file.
module rf_alu_pipe #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int IMM_W    = 5
) (
    input logic          clk,
    input logic          Reset,
    rf_alu_pipe_if.slave bus
);
    localparam int HALF_W = DATA_W / 2;
    localparam int SH_W   = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, li_q, li_d;
    logic [DATA_W-1:0] res_q, res_d, sh_q, sh_d;
    logic [3:0]        psw_q, psw_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic              sh_c_q, sh_c_d, dir_q, dir_d;
    logic              flag_q, flag_d, done_q, done_d;
    state_t            state_q, state_d;

    logic              wr_en;
    logic [DATA_W-1:0] wb_val, rm_data, rd_data;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] b_op, alu_res;
    logic [DATA_W:0]   sum;
    logic              cin, alu_c, alu_v;
    logic [SH_W-1:0]   sh_n;

    assign wr_en   = bus.WBRF && (bus.WBresource != 2'b11);
    assign rb_addr = bus.RBresource ? bus.RdAddr : bus.RnAddr;
    assign sh_n    = b_q[SH_W-1:0];

    always_comb begin
        case (bus.WBresource)
            2'b01:   wb_val = res_q;
            2'b10:   wb_val = li_q;
            default: wb_val = bus.WBData;
        endcase
    end

`ifdef RF_BYPASS_EN
    always_comb begin
        rm_data = rf_q[bus.RmAddr];
        rd_data = rf_q[rb_addr];
        if (wr_en && (bus.RmAddr == bus.WAddr)) rm_data = wb_val;
        if (wr_en && (rb_addr == bus.WAddr))    rd_data = wb_val;
    end
`else
    assign rm_data = rf_q[bus.RmAddr];
    assign rd_data = rf_q[rb_addr];
`endif

    always_comb begin
        rf_d = rf_q;
        if (wr_en) rf_d[bus.WAddr] = wb_val;
    end

    // Subtraction is A + ~B + cin, so C=1 means no borrow.
    always_comb begin
        b_op = (bus.ALUop[1] && !bus.ALUop[2]) ? ~b_q : b_q;
        case (bus.ALUop)
            3'b000:  cin = 1'b0;
            3'b010:  cin = 1'b1;
            default: cin = psw_q[3];
        endcase
        sum = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[DATA_W-1] == b_op[DATA_W-1]) &&
                  (sum[DATA_W-1] != a_q[DATA_W-1]);
        case (bus.ALUop)
            3'b100:  begin alu_res = a_q & b_q; alu_c = psw_q[3]; alu_v = 1'b0; end
            3'b101:  begin alu_res = a_q | b_q; alu_c = psw_q[3]; alu_v = 1'b0; end
            3'b110:  begin alu_res = a_q ^ b_q; alu_c = psw_q[3]; alu_v = 1'b0; end
            3'b111:  begin alu_res = a_q;       alu_c = psw_q[3]; alu_v = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        li_d    = li_q;
        res_d   = res_q;
        psw_d   = psw_q;
        sh_d    = sh_q;
        sh_c_d  = sh_c_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.Buff_IDEXE) begin
                    a_d  = rm_data;
                    b_d  = bus.OprandB ? {{(DATA_W-IMM_W){1'b0}}, bus.Imm} : rd_data;
                    li_d = bus.LI ? {{(DATA_W-HALF_W){1'b0}}, bus.ImmL}
                                  : {bus.ImmL, rd_data[HALF_W-1:0]};
                end
                if (bus.Exec) begin
                    if (bus.ALUop != 3'b111 || sh_n == '0) begin
                        res_d  = alu_res;
                        done_d = 1'b1;
                        if (bus.Flag)
                            psw_d = {alu_c, alu_res == '0, alu_res[DATA_W-1], alu_v};
                    end else begin
                        state_d = SHIFT;
                        sh_d    = a_q;
                        sh_c_d  = psw_q[3];
                        cnt_d   = sh_n;
                        dir_d   = bus.ShRight;
                        flag_d  = bus.Flag;
                    end
                end
            end
            SHIFT: begin
                sh_d   = dir_q ? (sh_q >> 1) : (sh_q << 1);
                sh_c_d = dir_q ? sh_q[0] : sh_q[DATA_W-1];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SH_W'(1)) begin
                    state_d = IDLE;
                    res_d   = sh_d;
                    done_d  = 1'b1;
                    if (flag_q)
                        psw_d = {sh_c_d, sh_d == '0, sh_d[DATA_W-1], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            li_q    <= '0;
            res_q   <= '0;
            psw_q   <= '0;
            sh_q    <= '0;
            sh_c_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            rf_q    <= rf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            li_q    <= li_d;
            res_q   <= res_d;
            psw_q   <= psw_d;
            sh_q    <= sh_d;
            sh_c_q  <= sh_c_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign bus.RmData  = rm_data;
    assign bus.RdData  = rd_data;
    assign bus.ResultR = res_q;
    assign bus.LI_q    = li_q;
    assign bus.PSW     = psw_q;
    assign bus.Busy    = (state_q == SHIFT);
    assign bus.Done    = done_q;
endmodule

// File: tb/tb_rf_alu_pipe.sv
// tb_rf_alu_pipe: scoreboard bench for rf_alu_pipe.
// Expected {ResultR, PSW} pairs are queued at Exec and compared at Done.
module tb_rf_alu_pipe;
    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    rf_alu_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .IMM_W(IW)) bus();

    rf_alu_pipe #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .IMM_W(IW)) dut (
        .clk(clk),
        .Reset(Reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] res;
        logic [3:0]    psw;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.WAddr = '0; bus.RmAddr = '0; bus.RnAddr = '0; bus.RdAddr = '0;
        bus.Imm = '0; bus.ImmL = '0; bus.WBData = '0; bus.WBRF = 1'b0;
        bus.WBresource = 2'b00; bus.RBresource = 1'b0; bus.OprandB = 1'b0;
        bus.LI = 1'b0; bus.Buff_IDEXE = 1'b0; bus.Exec = 1'b0;
        bus.ALUop = 3'b000; bus.ShRight = 1'b0; bus.Flag = 1'b0;
    endtask

    task automatic wr_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.WAddr = a; bus.WBData = d; bus.WBresource = 2'b00; bus.WBRF = 1'b1;
        tick();
        bus.WBRF = 1'b0;
    endtask

    task automatic buf_regs(input logic [AW-1:0] rm, input logic [AW-1:0] rn);
        bus.RmAddr = rm; bus.RnAddr = rn; bus.RBresource = 1'b0;
        bus.OprandB = 1'b0; bus.Buff_IDEXE = 1'b1;
        tick();
        bus.Buff_IDEXE = 1'b0;
    endtask

    task automatic buf_imm(input logic [AW-1:0] rm, input logic [IW-1:0] imm);
        bus.RmAddr = rm; bus.Imm = imm; bus.OprandB = 1'b1; bus.Buff_IDEXE = 1'b1;
        tick();
        bus.Buff_IDEXE = 1'b0;
    endtask

    // Pushes the expectation, pulses Exec and waits (bounded) for Done.
    task automatic exec_op(input logic [2:0] op, input logic shr, input logic flg,
                           input logic [DW-1:0] er, input logic [3:0] ep,
                           output int lat);
        exp_q.push_back('{res: er, psw: ep});
        bus.ALUop = op; bus.ShRight = shr; bus.Flag = flg; bus.Exec = 1'b1;
        tick();
        bus.Exec = 1'b0;
        lat = 1;
        while (!bus.Done && lat < 40) begin
            tick();
            lat++;
        end
        if (!bus.Done) lat = -1;
    endtask

    task automatic test_reset();
        int bad;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if (bus.ResultR !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.ResultR); end
        checks++;
        if (bus.PSW !== 4'h0) begin errors++; $display("FAIL reset_psw got=%b exp=0000", bus.PSW); end
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done got=%b%b exp=00", bus.Busy, bus.Done);
        end
        checks++;
        if (bus.LI_q !== '0) begin errors++; $display("FAIL reset_li got=%h exp=0", bus.LI_q); end
        bad = 0;
        for (int i = 0; i < NR; i++) begin
            bus.RmAddr = AW'(i);
            #1;
            if (bus.RmData !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_rf got=%0d nonzero exp=0", bad); end
    endtask

    task automatic test_add();
        int   lat;
        exp_t e;
        wr_reg(3'd1, 16'h7FFF);
        wr_reg(3'd2, 16'h0001);
        buf_regs(3'd1, 3'd2);
        exec_op(3'b000, 1'b0, 1'b1, 16'h8000, 4'b0011, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        e = exp_q.pop_front();
        checks++;
        if ({bus.ResultR, bus.PSW} !== e) begin
            errors++; $display("FAIL add_result got=%h/%b exp=%h/%b", bus.ResultR, bus.PSW, e.res, e.psw);
        end
        tick();
        checks++;
        if (bus.Done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got=%b exp=0", bus.Done); end
    endtask

    task automatic test_sub();
        int   lat;
        exp_t e;
        wr_reg(3'd3, 16'h0005);
        wr_reg(3'd4, 16'h0005);
        buf_regs(3'd3, 3'd4);
        exec_op(3'b010, 1'b0, 1'b1, 16'h0000, 4'b1100, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != 1 || {bus.ResultR, bus.PSW} !== e) begin
            errors++; $display("FAIL sub_result got=%h/%b lat=%0d exp=%h/%b", bus.ResultR, bus.PSW, lat, e.res, e.psw);
        end
        wr_reg(3'd3, 16'h0000);
        wr_reg(3'd4, 16'h0001);
        buf_regs(3'd3, 3'd4);
        exec_op(3'b011, 1'b0, 1'b1, 16'hFFFF, 4'b0010, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != 1 || {bus.ResultR, bus.PSW} !== e) begin
            errors++; $display("FAIL sbb_result got=%h/%b lat=%0d exp=%h/%b", bus.ResultR, bus.PSW, lat, e.res, e.psw);
        end
    endtask

    task automatic test_logic();
        logic [2:0]    ops [6] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b000, 3'b001};
        logic          flg [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [DW-1:0] ers [6] = '{16'hEFF0, 16'hF000, 16'hFFF0, 16'h0FF0, 16'hEFF0, 16'hEFF1};
        logic [3:0]    eps [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1010};
        int   lat;
        exp_t e;
        wr_reg(3'd5, 16'hF0F0);
        wr_reg(3'd6, 16'hFF00);
        buf_regs(3'd5, 3'd6);
        for (int i = 0; i < 6; i++) begin
            exec_op(ops[i], 1'b0, flg[i], ers[i], eps[i], lat);
            e = exp_q.pop_front();
            checks++;
            if (lat != 1 || {bus.ResultR, bus.PSW} !== e) begin
                errors++;
                $display("FAIL logic_op%0d got=%h/%b lat=%0d exp=%h/%b", i, bus.ResultR, bus.PSW, lat, e.res, e.psw);
            end
        end
    endtask

    task automatic test_li();
        wr_reg(3'd7, 16'h1234);
        bus.RdAddr = 3'd7; bus.RBresource = 1'b1; bus.LI = 1'b0; bus.ImmL = 8'hAB;
        #1;
        checks++;
        if (bus.RdData !== 16'h1234) begin errors++; $display("FAIL rd_select got=%h exp=1234", bus.RdData); end
        bus.Buff_IDEXE = 1'b1;
        tick();
        bus.Buff_IDEXE = 1'b0;
        checks++;
        if (bus.LI_q !== 16'hAB34) begin errors++; $display("FAIL lhi got=%h exp=ab34", bus.LI_q); end
        bus.WAddr = 3'd2; bus.WBresource = 2'b10; bus.WBRF = 1'b1;
        tick();
        bus.WBRF = 1'b0; bus.RmAddr = 3'd2;
        #1;
        checks++;
        if (bus.RmData !== 16'hAB34) begin errors++; $display("FAIL lhi_wb got=%h exp=ab34", bus.RmData); end
        bus.WBresource = 2'b11; bus.WBData = 16'hFFFF; bus.WBRF = 1'b1;
        tick();
        bus.WBRF = 1'b0;
        #1;
        checks++;
        if (bus.RmData !== 16'hAB34) begin errors++; $display("FAIL wb_reserved got=%h exp=ab34", bus.RmData); end
        bus.LI = 1'b1; bus.ImmL = 8'hCD; bus.Buff_IDEXE = 1'b1;
        tick();
        bus.Buff_IDEXE = 1'b0; bus.RBresource = 1'b0;
        checks++;
        if (bus.LI_q !== 16'h00CD) begin errors++; $display("FAIL lli got=%h exp=00cd", bus.LI_q); end
    endtask

    task automatic test_shift();
        int   lat;
        int   busy_cnt;
        exp_t e;
        wr_reg(3'd1, 16'h8001);
        wr_reg(3'd2, 16'h00FF);
        buf_imm(3'd1, 5'd3);
        for (int rep = 0; rep < 2; rep++) begin
            exp_q.push_back('{res: 16'h0008, psw: 4'b0000});
            bus.ALUop = 3'b111; bus.ShRight = 1'b0; bus.Flag = 1'b1; bus.Exec = 1'b1;
            tick();
            bus.Exec = 1'b0;
            lat = 1;
            busy_cnt = 0;
            while (!bus.Done && lat < 40) begin
                if (bus.Busy) busy_cnt++;
                if (lat == 1) begin
                    // Mid-shift Exec/Buff with different operands must be ignored.
                    bus.RmAddr = 3'd2; bus.Imm = 5'd1; bus.ALUop = 3'b000;
                    bus.Exec = 1'b1; bus.Buff_IDEXE = 1'b1;
                end else begin
                    bus.Exec = 1'b0; bus.Buff_IDEXE = 1'b0;
                end
                tick();
                lat++;
            end
            bus.Exec = 1'b0; bus.Buff_IDEXE = 1'b0;
            checks++;
            if (lat != 4 || busy_cnt != 3 || bus.Busy !== 1'b0) begin
                errors++; $display("FAIL shift%0d_timing got lat=%0d busy=%0d exp lat=4 busy=3", rep, lat, busy_cnt);
            end
            e = exp_q.pop_front();
            checks++;
            if ({bus.ResultR, bus.PSW} !== e) begin
                errors++; $display("FAIL shift%0d_result got=%h/%b exp=%h/%b", rep, bus.ResultR, bus.PSW, e.res, e.psw);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int   lat;
        int   bad;
        exp_t e;
        wr_reg(3'd1, 16'hFFFF);
        buf_imm(3'd1, 5'd8);
        exec_op(3'b000, 1'b0, 1'b1, 16'h0007, 4'b1000, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != 1 || {bus.ResultR, bus.PSW} !== e) begin
            errors++; $display("FAIL pre_shift_add got=%h/%b exp=%h/%b", bus.ResultR, bus.PSW, e.res, e.psw);
        end
        bus.ALUop = 3'b111; bus.ShRight = 1'b1; bus.Flag = 1'b1; bus.Exec = 1'b1;
        tick();
        bus.Exec = 1'b0;
        checks++;
        if (bus.Busy !== 1'b1) begin errors++; $display("FAIL shift8_busy got=%b exp=1", bus.Busy); end
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.ResultR !== '0 || bus.PSW !== 4'h0) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b res=%h psw=%b exp 0/0/0/0", bus.Busy, bus.Done, bus.ResultR, bus.PSW);
        end
        bad = 0;
        for (int i = 0; i < NR; i++) begin
            bus.RmAddr = AW'(i);
            #1;
            if (bus.RmData !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_rf got=%0d nonzero exp=0", bad); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_no_done got=%0d cycles exp=0", bad); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_same;
`ifdef RF_BYPASS_EN
        exp_same = 16'h5A5A;
`else
        exp_same = 16'h1111;
`endif
        wr_reg(3'd5, 16'h1111);
        bus.WAddr = 3'd5; bus.RmAddr = 3'd5; bus.RnAddr = 3'd5; bus.RBresource = 1'b0;
        bus.WBData = 16'h5A5A; bus.WBresource = 2'b00; bus.WBRF = 1'b1;
        #1;
        checks++;
        if (bus.RmData !== exp_same || bus.RdData !== exp_same) begin
            errors++; $display("FAIL same_cycle_read got=%h/%h exp=%h", bus.RmData, bus.RdData, exp_same);
        end
        tick();
        bus.WBRF = 1'b0;
        #1;
        checks++;
        if (bus.RmData !== 16'h5A5A) begin errors++; $display("FAIL next_cycle_read got=%h exp=5a5a", bus.RmData); end
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_li();
        test_shift();
        test_reset_mid_shift();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
